// File: rtl/filter_mode_sequencer.sv
// Frame-synchronous step-button debouncer and channel-enable mode sequencer for the VGA delta filter.
// Build macro FILTER_AUTO_CYCLE_EN adds an auto-advance of the mode every AUTO_FRAMES commits.
module filter_mode_sequencer #(
  parameter int unsigned HEIGHT       = 480,
  parameter int unsigned DEBOUNCE_CYC = 250000,
  parameter int unsigned AUTO_FRAMES  = 60
) (
  input  logic        VGA_CLK,
  input  logic        reset_n,
  input  logic        iVGA_VS,
  input  logic        iVGA_BLANK_N,
  input  logic        key_n,
  input  logic        sw_manual,
  input  logic [2:0]  sw_chan,
  output logic [2:0]  chan_en,
  output logic [1:0]  mode_idx,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic [9:0]  line_cnt,
  output logic        line_err
);

  localparam int unsigned DbW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);
  localparam logic [9:0] HeightL = 10'(HEIGHT);

  typedef enum logic [1:0] {StWaitSync, StVblank, StFrame} state_e;

  state_e         state_q, state_d;
  logic           vs_q, blank_q;
  logic           key_s1_q, key_s2_q;
  logic           key_db_q, key_db_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]     pending_q, pending_d;
  logic [2:0]     chan_en_q, chan_en_d;
  logic [1:0]     mode_q, mode_d;
  logic           frame_start_q;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [9:0]     line_cnt_q, line_cnt_d;
  logic           line_err_q, line_err_d;
  logic           vs_fall, vs_rise, blank_rise;
  logic           commit, check, press, advance;

  assign vs_fall    = vs_q & ~iVGA_VS;
  assign vs_rise    = ~vs_q & iVGA_VS;
  assign blank_rise = ~blank_q & iVGA_BLANK_N;

  function automatic logic [2:0] mode_chan(input logic [1:0] m);
    logic [2:0] c;
    unique case (m)
      2'd0: c = 3'b000;
      2'd1: c = 3'b001;
      2'd2: c = 3'b010;
      2'd3: c = 3'b100;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    check   = 1'b0;
    case (state_q)
      StWaitSync: if (vs_fall) begin
        state_d = StVblank;
        commit  = 1'b1;
      end
      StVblank: if (vs_rise) state_d = StFrame;
      StFrame: if (vs_fall) begin
        state_d = StVblank;
        commit  = 1'b1;
        check   = 1'b1;
      end
      default: state_d = StWaitSync;
    endcase
  end

  // A level is accepted once the synchronized key has differed from it for DEBOUNCE_CYC samples.
  always_comb begin
    db_cnt_d = db_cnt_q;
    key_db_d = key_db_q;
    press    = 1'b0;
    if (key_s2_q == key_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      db_cnt_d = '0;
      key_db_d = key_s2_q;
      press    = ~key_s2_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

`ifdef FILTER_AUTO_CYCLE_EN
  localparam int unsigned AutoW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_FRAMES - 1);
  logic [AutoW-1:0] auto_cnt_q, auto_cnt_d;
  logic             auto_wrap;

  assign auto_wrap = commit && (auto_cnt_q == AutoLast);

  always_comb begin
    auto_cnt_d = auto_cnt_q;
    if (press)       auto_cnt_d = '0;
    else if (commit) auto_cnt_d = auto_wrap ? '0 : auto_cnt_q + 1'b1;
  end

  always_ff @(posedge VGA_CLK) begin
    if (!reset_n) auto_cnt_q <= '0;
    else          auto_cnt_q <= auto_cnt_d;
  end

  // A press and a wrap on the same cycle still advance only once.
  assign advance = (press | auto_wrap) & ~sw_manual;
`else
  logic unused_auto_frames;
  assign unused_auto_frames = ^AUTO_FRAMES;
  assign advance = press & ~sw_manual;
`endif

  // Commit samples the old pending value; a coincident advance lands for the next commit.
  always_comb begin
    pending_d   = advance ? pending_q + 2'd1 : pending_q;
    chan_en_d   = chan_en_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    line_cnt_d  = line_cnt_q;
    line_err_d  = line_err_q | (check && (line_cnt_q != HeightL));
    if (commit) begin
      mode_d      = pending_q;
      chan_en_d   = sw_manual ? sw_chan : mode_chan(pending_q);
      frame_cnt_d = frame_cnt_q + 16'd1;
      line_cnt_d  = '0;
    end else if (state_q == StFrame && blank_rise && line_cnt_q != 10'h3FF) begin
      line_cnt_d  = line_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (!reset_n) begin
      state_q       <= StWaitSync;
      vs_q          <= 1'b0;
      blank_q       <= 1'b0;
      key_s1_q      <= 1'b1;
      key_s2_q      <= 1'b1;
      key_db_q      <= 1'b1;
      db_cnt_q      <= '0;
      pending_q     <= '0;
      chan_en_q     <= '0;
      mode_q        <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      line_cnt_q    <= '0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= iVGA_VS;
      blank_q       <= iVGA_BLANK_N;
      key_s1_q      <= key_n;
      key_s2_q      <= key_s1_q;
      key_db_q      <= key_db_d;
      db_cnt_q      <= db_cnt_d;
      pending_q     <= pending_d;
      chan_en_q     <= chan_en_d;
      mode_q        <= mode_d;
      frame_start_q <= commit;
      frame_cnt_q   <= frame_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_err_q    <= line_err_d;
    end
  end

  assign chan_en     = chan_en_q;
  assign mode_idx    = mode_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
  assign line_cnt    = line_cnt_q;
  assign line_err    = line_err_q;

endmodule

// File: tb/tb_filter_mode_sequencer.sv
// Scoreboard bench for filter_mode_sequencer: expected commits are queued as each VS fall is
// driven and popped when frame_start appears. Define FILTER_AUTO_CYCLE_EN to add the auto test.
`timescale 1ns/1ps
module tb_filter_mode_sequencer;
  localparam int Height = 10;

  logic        VGA_CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic        iVGA_VS = 1'b0;
  logic        iVGA_BLANK_N = 1'b0;
  logic        key_n = 1'b1;
  logic        sw_manual = 1'b0;
  logic [2:0]  sw_chan = 3'b000;
  logic [2:0]  chan_en;
  logic [1:0]  mode_idx;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic [9:0]  line_cnt;
  logic        line_err;

  filter_mode_sequencer #(
    .HEIGHT      (Height),
    .DEBOUNCE_CYC(4),
    .AUTO_FRAMES (3)
  ) dut (
    .VGA_CLK     (VGA_CLK),
    .reset_n     (reset_n),
    .iVGA_VS     (iVGA_VS),
    .iVGA_BLANK_N(iVGA_BLANK_N),
    .key_n       (key_n),
    .sw_manual   (sw_manual),
    .sw_chan     (sw_chan),
    .chan_en     (chan_en),
    .mode_idx    (mode_idx),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt),
    .line_cnt    (line_cnt),
    .line_err    (line_err)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  typedef struct packed {
    logic [1:0]  mode;
    logic [2:0]  chan;
    logic [15:0] fcnt;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int pulses = 0;

  // Reference model state
  logic [1:0]  m_pend;
  logic [1:0]  m_mode;
  logic [2:0]  m_chan;
  logic [15:0] m_fcnt;
  logic        m_err;
  logic        m_first;
  int          m_auto;

  always @(negedge VGA_CLK) if (reset_n && frame_start === 1'b1) pulses++;

  function automatic logic [2:0] tbl(input logic [1:0] m);
    logic [2:0] t [4];
    t[0] = 3'b000; t[1] = 3'b001; t[2] = 3'b010; t[3] = 3'b100;
    return t[m];
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge VGA_CLK);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    iVGA_VS = 1'b0;
    iVGA_BLANK_N = 1'b0;
    key_n = 1'b1;
    sw_manual = 1'b0;
    sw_chan = 3'b000;
    cyc(2);
    m_pend = 0; m_mode = 0; m_chan = 0; m_fcnt = 0; m_err = 0; m_first = 1; m_auto = 0;
    sb_q.delete();
    n_tests++;
    if ({chan_en, mode_idx, frame_start, frame_cnt, line_cnt, line_err} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got chan=%b mode=%0d fs=%b fcnt=%0d lcnt=%0d err=%b, want all 0",
               chan_en, mode_idx, frame_start, frame_cnt, line_cnt, line_err);
    end
    reset_n = 1'b1;
    cyc(2);
  endtask

  task automatic begin_frame();
    iVGA_VS = 1'b1;
    cyc(3);
  endtask

  // Lines, then VS fall; expected commit is queued and checked against the frame_start cycle.
  task automatic end_frame(input int lines, input bit press_on_fall);
    exp_t e, got;
    int   exp_lc;
    bit   found;
    bit   wrap;
    for (int i = 0; i < lines; i++) begin
      iVGA_BLANK_N = 1'b0; cyc(2);
      iVGA_BLANK_N = 1'b1; cyc(6);
    end
    iVGA_BLANK_N = 1'b0;
    cyc(2);
    exp_lc = m_first ? 0 : (lines > 1023 ? 1023 : lines);
    n_tests++;
    if (line_cnt !== 10'(exp_lc)) begin
      n_fail++;
      $display("FAIL line_cnt: got %0d, want %0d", line_cnt, exp_lc);
    end
    if (press_on_fall) begin
      key_n = 1'b0;
      cyc(5);
    end
    e.mode = m_pend;
    e.chan = sw_manual ? sw_chan : tbl(m_pend);
    m_fcnt = m_fcnt + 16'd1;
    e.fcnt = m_fcnt;
    if (!m_first && lines != Height) m_err = 1'b1;
    e.err = m_err;
    m_first = 1'b0;
    m_mode = e.mode;
    m_chan = e.chan;
    sb_q.push_back(e);
`ifdef FILTER_AUTO_CYCLE_EN
    wrap = (m_auto == 2);
    if (press_on_fall) m_auto = 0;
    else m_auto = wrap ? 0 : m_auto + 1;
`else
    wrap = 1'b0;
`endif
    if (!sw_manual && (press_on_fall || wrap)) m_pend = m_pend + 2'd1;
    iVGA_VS = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      cyc(1);
      if (frame_start === 1'b1) found = 1'b1;
    end
    e = sb_q.pop_front();
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL frame_start_timeout: got no pulse within 4 cycles, want pulse for frame %0d",
               e.fcnt);
    end else begin
      got = {mode_idx, chan_en, frame_cnt, line_err};
      if (got !== e) begin
        n_fail++;
        $display("FAIL commit: got mode=%0d chan=%b fcnt=%0d err=%b, want mode=%0d chan=%b fcnt=%0d err=%b",
                 got.mode, got.chan, got.fcnt, got.err, e.mode, e.chan, e.fcnt, e.err);
      end
      n_tests++;
      if (line_cnt !== 10'd0) begin
        n_fail++;
        $display("FAIL line_cnt_clear: got %0d, want 0", line_cnt);
      end
      cyc(1);
      n_tests++;
      if (frame_start !== 1'b0) begin
        n_fail++;
        $display("FAIL frame_start_width: got %b a cycle after pulse, want 0", frame_start);
      end
    end
    if (press_on_fall) begin
      cyc(2);
      key_n = 1'b1;
    end
    cyc(8);
  endtask

  task automatic press_key(input int low);
    key_n = 1'b0;
    cyc(low);
    key_n = 1'b1;
    cyc(8);
    if (low >= 6) begin
      if (!sw_manual) m_pend = m_pend + 2'd1;
      m_auto = 0;
    end
  endtask

  task automatic check_held(input string name);
    n_tests++;
    if (chan_en !== m_chan || mode_idx !== m_mode) begin
      n_fail++;
      $display("FAIL %s: got chan=%b mode=%0d, want chan=%b mode=%0d",
               name, chan_en, mode_idx, m_chan, m_mode);
    end
  endtask

  task automatic test_reset();
    int p0;
    do_reset();
    p0 = pulses;
    repeat (3) begin
      begin_frame();
      end_frame(Height, 1'b0);
    end
    n_tests++;
    if (pulses - p0 !== 3) begin
      n_fail++;
      $display("FAIL pulse_count: got %0d, want 3", pulses - p0);
    end
    n_tests++;
    if (frame_cnt !== 16'd3 || line_err !== 1'b0) begin
      n_fail++;
      $display("FAIL three_frames: got fcnt=%0d err=%b, want fcnt=3 err=0", frame_cnt, line_err);
    end
  endtask

  task automatic test_press();
    begin_frame();
    press_key(6);
    check_held("press_held_midframe");
    end_frame(Height, 1'b0);
  endtask

  task automatic test_short_press();
    begin_frame();
    press_key(3);
    end_frame(Height, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    begin_frame();
    end_frame(Height, 1'b0);
    begin_frame();
    repeat (4) press_key(6);
    end_frame(Height, 1'b0);
  endtask

  task automatic test_back_to_back();
    begin_frame();
    repeat (2) press_key(6);
    end_frame(Height, 1'b1);
    begin_frame();
    end_frame(Height, 1'b0);
  endtask

  task automatic test_manual();
    begin_frame();
    sw_manual = 1'b1;
    sw_chan = 3'b101;
    cyc(2);
    check_held("manual_held_midframe");
    press_key(6);
    end_frame(Height, 1'b0);
    begin_frame();
    press_key(6);
    end_frame(Height, 1'b0);
    begin_frame();
    sw_manual = 1'b0;
    end_frame(Height, 1'b0);
  endtask

  task automatic test_line_err();
    begin_frame();
    end_frame(9, 1'b0);
    begin_frame();
    end_frame(Height, 1'b0);
    n_tests++;
    if (line_err !== 1'b1) begin
      n_fail++;
      $display("FAIL line_err_sticky: got %b, want 1", line_err);
    end
  endtask

  task automatic test_mid_reset();
    begin_frame();
    for (int i = 0; i < 2; i++) begin
      iVGA_BLANK_N = 1'b1; cyc(4);
      iVGA_BLANK_N = 1'b0; cyc(2);
    end
    reset_n = 1'b0;
    cyc(1);
    n_tests++;
    if ({chan_en, mode_idx, frame_start, frame_cnt, line_cnt, line_err} !== 33'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got chan=%b mode=%0d fcnt=%0d lcnt=%0d err=%b, want all 0",
               chan_en, mode_idx, frame_cnt, line_cnt, line_err);
    end
    reset_n = 1'b1;
    m_pend = 0; m_mode = 0; m_chan = 0; m_fcnt = 0; m_err = 0; m_first = 1; m_auto = 0;
    end_frame(5, 1'b0);
    begin_frame();
    end_frame(Height, 1'b0);
  endtask

`ifdef FILTER_AUTO_CYCLE_EN
  task automatic test_auto();
    do_reset();
    repeat (13) begin
      begin_frame();
      end_frame(Height, 1'b0);
    end
    begin_frame();
    press_key(6);
    end_frame(Height, 1'b0);
    repeat (4) begin
      begin_frame();
      end_frame(Height, 1'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_press();
    test_short_press();
    test_wrap();
    test_back_to_back();
    test_manual();
    test_line_err();
    test_mid_reset();
`ifdef FILTER_AUTO_CYCLE_EN
    test_auto();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish by 500000 ns, want completion");
    $fatal(1);
  end

endmodule
